// File: rtl/counter_monitor.sv
// Passive shadow-model checker for a loadable up-counter: flags count/expected divergence.
// Optional COUNTER_MONITOR_RESYNC_EN: realign the shadow to the observed count after a mismatch.
module counter_monitor #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned ERR_W = 8,
   parameter int unsigned CHK_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] data,
   input  logic [WIDTH-1:0] count,
   input  logic             check_en,
   output logic [WIDTH-1:0] expected,
   output logic             mismatch,
   output logic             fail,
   output logic [ERR_W-1:0] err_count,
   output logic [CHK_W-1:0] chk_count,
   output logic [WIDTH-1:0] first_exp,
   output logic [WIDTH-1:0] first_obs
);

   localparam logic [1:0] ARM    = 2'd0;
   localparam logic [1:0] CHECK  = 2'd1;
   localparam logic [1:0] FAILED = 2'd2;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic             cmp;
   logic             miss;
   logic             capture;
   logic [WIDTH-1:0] exp_q;
   logic [WIDTH-1:0] exp_base;
   logic [WIDTH-1:0] exp_nxt;
   logic [ERR_W-1:0] err_nxt;
   logic [CHK_W-1:0] chk_nxt;

   // Next state and compare qualification
   always_comb begin
      state_nxt = state;
      cmp       = 1'b0;
      miss      = 1'b0;
      case (state)
         ARM: begin
            state_nxt = CHECK;
         end
         CHECK: begin
            cmp  = check_en;
            miss = check_en && (count != exp_q);
            if (miss) begin
               state_nxt = FAILED;
            end
         end
         FAILED: begin
            cmp  = check_en;
            miss = check_en && (count != exp_q);
         end
         default: begin
            state_nxt = ARM;
         end
      endcase
   end

   // Shadow counter advance and statistics next values
   always_comb begin
      exp_base = exp_q;
`ifdef COUNTER_MONITOR_RESYNC_EN
      if (miss) begin
         exp_base = count;
      end
`endif
      exp_nxt = load ? data : exp_base + WIDTH'(1);
      chk_nxt = cmp ? chk_count + CHK_W'(1) : chk_count;
      err_nxt = (miss && (err_count != {ERR_W{1'b1}})) ? err_count + ERR_W'(1) : err_count;
      capture = miss && (state == CHECK);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ARM;
         exp_q     <= '0;
         mismatch  <= 1'b0;
         fail      <= 1'b0;
         err_count <= '0;
         chk_count <= '0;
         first_exp <= '0;
         first_obs <= '0;
      end else begin
         state     <= state_nxt;
         exp_q     <= exp_nxt;
         mismatch  <= miss;
         fail      <= fail | miss;
         err_count <= err_nxt;
         chk_count <= chk_nxt;
         if (capture) begin
            first_exp <= exp_q;
            first_obs <= count;
         end
      end
   end

   assign expected = exp_q;

endmodule

// File: tb/tb_counter_monitor.sv
// Bench for counter_monitor: an observed counter with fault injection, a behavioural
// reference model compared every cycle, plus directed literal checks.
module tb_counter_monitor;
   localparam int unsigned WIDTH = 4;
   localparam int unsigned ERR_W = 8;
   localparam int unsigned CHK_W = 16;
`ifdef COUNTER_MONITOR_RESYNC_EN
   localparam bit RESYNC = 1'b1;
`else
   localparam bit RESYNC = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             reset, load, check_en;
   logic [WIDTH-1:0] data, count;
   logic [WIDTH-1:0] expected, first_exp, first_obs;
   logic             mismatch, fail;
   logic [ERR_W-1:0] err_count;
   logic [CHK_W-1:0] chk_count;

   // Observed counter, with a state jam (real counter fault) and a count-only glitch override
   logic [WIDTH-1:0] ctr;
   logic             jam_en;
   logic [WIDTH-1:0] jam_val;
   int               gmode;
   logic [WIDTH-1:0] gval;

   always @(posedge clk)
      ctr <= reset ? 4'd0 : load ? data : jam_en ? jam_val : ctr + 4'd1;

   always_comb count = (gmode == 1) ? gval : (gmode == 2) ? ~ctr : ctr;

   counter_monitor #(.WIDTH(WIDTH), .ERR_W(ERR_W), .CHK_W(CHK_W)) dut (
      .clk(clk), .reset(reset), .load(load), .data(data), .count(count),
      .check_en(check_en), .expected(expected), .mismatch(mismatch), .fail(fail),
      .err_count(err_count), .chk_count(chk_count),
      .first_exp(first_exp), .first_obs(first_obs)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference model: what each output must be after every edge
   int m_exp = 0, m_armed = 0, m_fail = 0, m_mis = 0, m_err = 0, m_chk = 0, m_fe = 0, m_fo = 0;
   bit started = 1'b0;

   always @(posedge clk) begin
      int  base;
      bit  do_cmp, bad;
      started = 1'b1;
      if (reset) begin
         m_exp = 0; m_armed = 0; m_fail = 0; m_mis = 0;
         m_err = 0; m_chk = 0;   m_fe = 0;   m_fo = 0;
      end else begin
         do_cmp = (m_armed != 0) && check_en;
         bad    = do_cmp && (int'(count) != m_exp);
         m_mis  = bad ? 1 : 0;
         if (do_cmp) m_chk = (m_chk + 1) % 65536;
         if (bad) begin
            if (m_fail == 0) begin
               m_fe = m_exp;
               m_fo = int'(count);
            end
            m_fail = 1;
            if (m_err < 255) m_err++;
         end
         base    = (RESYNC && bad) ? int'(count) : m_exp;
         m_exp   = load ? int'(data) : (base + 1) % 16;
         m_armed = 1;
      end
   end

   always @(negedge clk) begin
      if (started) begin
         check("m_expected",  int'(expected),  m_exp);
         check("m_mismatch",  int'(mismatch),  m_mis);
         check("m_fail",      int'(fail),      m_fail);
         check("m_err_count", int'(err_count), m_err);
         check("m_chk_count", int'(chk_count), m_chk);
         check("m_first_exp", int'(first_exp), m_fe);
         check("m_first_obs", int'(first_obs), m_fo);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; load = 1'b0; data = '0; check_en = 1'b1;
      jam_en = 1'b0; jam_val = '0; gmode = 0; gval = '0;
      step(); step();
      check("rst_expected", int'(expected), 0);
      check("rst_fail",     int'(fail), 0);
      check("rst_chk",      int'(chk_count), 0);
      check("rst_mismatch", int'(mismatch), 0);

      // ARM cycle then 20 clean compares
      reset = 1'b0;
      repeat (21) step();
      check("clean_chk",      int'(chk_count), 20);
      check("clean_err",      int'(err_count), 0);
      check("clean_fail",     int'(fail), 0);
      check("clean_expected", int'(expected), 5);

      load = 1'b1; data = 4'd3;
      step();
      load = 1'b0;
      check("load_exp3", int'(expected), 3);
      step();
      check("load_exp4", int'(expected), 4);

      // Counter jumps to 7 while shadow is at 5
      jam_en = 1'b1; jam_val = 4'd7;
      step();
      jam_en = 1'b0;
      check("jam_exp5",     int'(expected), 5);
      check("jam_pre_mis",  int'(mismatch), 0);
      step();
      check("jam_mismatch", int'(mismatch), 1);
      check("jam_fail",     int'(fail), 1);
      check("jam_first_exp", int'(first_exp), 5);
      check("jam_first_obs", int'(first_obs), 7);
      check("jam_err1",     int'(err_count), 1);
      repeat (5) step();
      check("jam_err_run",  int'(err_count), RESYNC ? 1 : 6);
      check("jam_first_hold", int'(first_exp), 5);

      load = 1'b1; data = 4'd2;
      step();
      load = 1'b0;
      step();
      check("realign_mis", int'(mismatch), 0);
      check("realign_err", int'(err_count), RESYNC ? 1 : 7);
      check("realign_exp", int'(expected), 3);

      // Reset beats load
      reset = 1'b1; load = 1'b1; data = 4'd9;
      step();
      check("rl_expected", int'(expected), 0);
      check("rl_fail",     int'(fail), 0);
      check("rl_err",      int'(err_count), 0);
      check("rl_chk",      int'(chk_count), 0);
      check("rl_first_obs", int'(first_obs), 0);
      reset = 1'b0; load = 1'b0; check_en = 1'b0;
      repeat (4) step();
      check("noen_chk", int'(chk_count), 0);
      check("noen_exp", int'(expected), 4);
      check_en = 1'b1;
      repeat (4) step();
      check("en_chk", int'(chk_count), 4);
      check("en_exp", int'(expected), 8);
      check("en_err", int'(err_count), 0);

      // Observed 9 against shadow 8
      gmode = 1; gval = 4'd9;
      step();
      gmode = 0;
      check("g9_mismatch",  int'(mismatch), 1);
      check("g9_first_exp", int'(first_exp), 8);
      check("g9_first_obs", int'(first_obs), 9);
      check("g9_err",       int'(err_count), 1);

      // Persistent fault saturates the error counter
      gmode = 2;
      repeat (300) step();
      check("sat_err",      int'(err_count), 255);
      check("sat_fail",     int'(fail), 1);
      check("sat_mismatch", int'(mismatch), 1);
      gmode = 0;

      // Mid-run reset after failure
      reset = 1'b1;
      step();
      check("mr_fail",      int'(fail), 0);
      check("mr_err",       int'(err_count), 0);
      check("mr_chk",       int'(chk_count), 0);
      check("mr_first_exp", int'(first_exp), 0);
      check("mr_first_obs", int'(first_obs), 0);
      check("mr_mismatch",  int'(mismatch), 0);
      check("mr_expected",  int'(expected), 0);
      reset = 1'b0;
      step();
      check("mr_arm_chk", int'(chk_count), 0);
      repeat (6) step();
      check("mr_resume_chk",  int'(chk_count), 6);
      check("mr_resume_err",  int'(err_count), 0);
      check("mr_resume_fail", int'(fail), 0);
      check("mr_resume_mis",  int'(mismatch), 0);

      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
